score_display: RTL and testbench

Consumes the running game score from `calc_score` and the `collide` flag, and drives a multiplexed, active-low 4-digit seven-segment display. It sits downstream of `calc_score`, alongside `display`, in the `LittleDinosaur` top level. A sequential double-dabble converter turns the binary score into BCD. The scan logic then time-multiplexes the digits, applies leading-zero blanking, and blinks the display while the game is paused on a collision.

---
 rtl/score_display_pkg.sv | 32 +++
 rtl/score_display_bin2bcd_seq.sv | 70 +++++++
 rtl/score_display.sv | 183 ++++++++++++++++++
 tb/tb_score_display.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/score_display_pkg.sv
// Shared constants and seven-segment patterns for the score display.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package score_display_pkg;

  localparam int SCORELEN = 13;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/score_display_bin2bcd_seq.sv
// Sequential double-dabble: one bit per cycle, SCORE_W shift cycles.
// done is high during LOAD so the consumer latches bcd on that edge.
module bin2bcd_seq
  import score_display_pkg::*;
#(
  parameter int SCORE_W = 14,
  parameter int DIGITS  = 4
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SCORE_W-1:0]    bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = $clog2(SCORE_W + 1);

  logic [1:0]          state;
  logic [SCORE_W-1:0]  shreg;
  logic [CW-1:0]       cnt;
  logic [4*DIGITS-1:0] adj;

  assign done = (state == ST_LOAD);

  // add-3 correction on every nibble that would overflow past 9 when doubled
  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // IDLE -> SHIFT (SCORE_W cycles) -> LOAD -> IDLE
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      shreg <= '0;
      cnt   <= '0;
      bcd   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            shreg <= bin;
            bcd   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          {bcd, shreg} <= {adj, shreg} << 1;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(SCORE_W - 1))
            state <= ST_LOAD;
        end
        ST_LOAD: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/score_display.sv
// Score to multiplexed 4-digit seven-segment display with blanking/blink.
// Define HISCORE_EN to show the high score during the blink off phase.
module score_display
  import score_display_pkg::*;
#(
  parameter int SCORE_W     = SCORELEN + 1,
  parameter int DIGITS      = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int BLINK_TICKS = 250
) (
  input  logic               clock,
  input  logic               rst,
  input  logic [SCORE_W-1:0] score,
  input  logic               collide,
  output logic [6:0]         seg,
  output logic [DIGITS-1:0]  an,
  output logic               busy,
  output logic               overflow
);

  localparam int unsigned LIMIT = 10 ** DIGITS;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [SCORE_W-1:0]  src;
  logic [SCORE_W-1:0]  sat_src;
  logic                src_ovf;
  logic [SCORE_W-1:0]  last_conv;
  logic [SCORE_W-1:0]  conv_src;
  logic                conv_ovf;
  logic                start;
  logic                done;
  logic [4*DIGITS-1:0] bcd;
  logic [4*DIGITS-1:0] disp_bcd;
  logic                req;
  logic                blank_an;

  logic [PW-1:0]       pre;
  logic [IW-1:0]       idx;
  logic                tick;
  logic [BW-1:0]       bcnt;
  logic                phase;
  logic [DIGITS-1:0]   lit;
  logic [3:0]          cur;

  // clamp anything the display cannot hold to all nines
  always_comb begin
    src_ovf = (32'(src) >= LIMIT);
    sat_src = src_ovf ? SCORE_W'(LIMIT - 1) : src;
  end

  assign start = !busy && ((sat_src != last_conv) || req);

  bin2bcd_seq #(
    .SCORE_W (SCORE_W),
    .DIGITS  (DIGITS)
  ) u_conv (
    .clock (clock),
    .rst   (rst),
    .start (start),
    .bin   (sat_src),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  // remember what is being converted; publish it when the converter loads
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      conv_src  <= '0;
      conv_ovf  <= 1'b0;
      last_conv <= '0;
      disp_bcd  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (start) begin
        conv_src <= sat_src;
        conv_ovf <= src_ovf;
      end
      if (done) begin
        disp_bcd  <= bcd;
        last_conv <= conv_src;
        overflow  <= conv_ovf;
      end
    end
  end

  assign tick = (pre == PW'(SCAN_DIV - 1));

  // digit-slot prescaler and scan index
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      pre <= '0;
      idx <= '0;
    end else if (tick) begin
      pre <= '0;
      idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // blink phase: toggles every BLINK_TICKS slots while paused
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      bcnt  <= '0;
      phase <= 1'b1;
    end else if (!collide) begin
      bcnt  <= '0;
      phase <= 1'b1;
    end else if (tick) begin
      if (bcnt == BW'(BLINK_TICKS - 1)) begin
        bcnt  <= '0;
        phase <= ~phase;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
    end
  end

`ifdef HISCORE_EN
  logic [SCORE_W-1:0] hiscore;
  logic               collide_q;
  logic               phase_tgl;

  assign phase_tgl = collide && tick && (bcnt == BW'(BLINK_TICKS - 1));
  assign src       = (collide && !phase) ? hiscore : score;
  assign blank_an  = 1'b0;

  // high score latches on each new collision
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      hiscore   <= '0;
      collide_q <= 1'b0;
    end else begin
      collide_q <= collide;
      if (collide && !collide_q && (score > hiscore))
        hiscore <= score;
    end
  end

  // force a fresh conversion on every phase change
  always_ff @(posedge clock or posedge rst) begin
    if (rst)
      req <= 1'b0;
    else if (phase_tgl)
      req <= 1'b1;
    else if (start)
      req <= 1'b0;
  end
`else
  assign src      = score;
  assign req      = 1'b0;
  assign blank_an = collide && !phase;
`endif

  // a digit is lit if it or any higher digit is nonzero; digit 0 always lit
  always_comb begin
    logic any;
    any = 1'b0;
    lit = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      any    = any | (disp_bcd[4*i +: 4] != 4'd0);
      lit[i] = any;
    end
    lit[0] = 1'b1;
  end

  assign cur = disp_bcd[{idx, 2'b00} +: 4];

  // registered segment and anode drive
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      seg <= SEG_ZERO;
      an  <= ~DIGITS'(1);
    end else begin
      seg <= lit[idx] ? seg7(cur) : SEG_BLANK;
      an  <= blank_an ? '1 : ~(DIGITS'(1) << idx);
    end
  end

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display with SCAN_DIV=4, BLINK_TICKS=2.
// Build with +define+HISCORE_EN to exercise the high-score path.
module tb_score_display;

  logic        clock = 1'b0;
  logic        rst;
  logic [13:0] score;
  logic        collide;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        busy;
  logic        overflow;

  int errs   = 0;
  int checks = 0;
  int n;
  int len;
  logic flag;

  always #5 clock = ~clock;

  score_display #(
    .SCORE_W     (14),
    .DIGITS      (4),
    .SCAN_DIV    (4),
    .BLINK_TICKS (2)
  ) dut (
    .clock    (clock),
    .rst      (rst),
    .score    (score),
    .collide  (collide),
    .seg      (seg),
    .an       (an),
    .busy     (busy),
    .overflow (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clock);
  endtask

  task automatic wait_conv(input string tag);
    int k = 0;
    while (!busy && k < 50) begin @(negedge clock); k++; end
    while (busy && k < 100) begin @(negedge clock); k++; end
    chk({tag, "_done"}, k < 100, 1);
    cyc(2);
  endtask

  task automatic show(input string tag, input int idx, input logic [6:0] exp);
    int k = 0;
    logic [3:0] want;
    want = ~(4'b0001 << idx);
    while (an !== want && k < 40) begin @(negedge clock); k++; end
    chk(tag, {an, seg}, {want, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; score = '0; collide = 1'b0;
    cyc(2);
    chk("rst_seg", seg, 7'b1000000);
    chk("rst_an", an, 4'b1110);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;
    cyc(3);
    chk("idle_busy", busy, 0);

    score = 14'd1234;
    n = 0;
    while (!busy && n < 10) begin @(negedge clock); n++; end
    len = 0;
    while (busy && len < 40) begin @(negedge clock); len++; end
    chk("busy_len", (len >= 15 && len <= 16), 1);
    cyc(2);
    show("c1234_d0", 0, 7'b0011001);
    show("c1234_d1", 1, 7'b0110000);
    show("c1234_d2", 2, 7'b0100100);
    show("c1234_d3", 3, 7'b1111001);

    score = 14'd7;
    wait_conv("c7");
    show("c7_d0", 0, 7'b1111000);
    show("c7_d1", 1, 7'h7F);
    show("c7_d2", 2, 7'h7F);
    show("c7_d3", 3, 7'h7F);

    score = 14'd12000;
    wait_conv("c12000");
    chk("ovf_set", overflow, 1);
    show("sat_d0", 0, 7'b0010000);
    show("sat_d1", 1, 7'b0010000);
    show("sat_d2", 2, 7'b0010000);
    show("sat_d3", 3, 7'b0010000);
    score = 14'd5;
    wait_conv("c5");
    chk("ovf_clr", overflow, 0);
    show("c5_d0", 0, 7'b0010010);
    show("c5_d1", 1, 7'h7F);

    score = 14'd100;
    n = 0;
    while (!busy && n < 10) begin @(negedge clock); n++; end
    cyc(2);
    score = 14'd101;
    n = 0;
    while (busy && n < 40) begin @(negedge clock); n++; end
    n = 0;
    while (!busy && n < 10) begin @(negedge clock); n++; end
    flag = busy;
    chk("reconv", flag, 1);
    wait_conv("c101");
    show("c101_d0", 0, 7'b1111001);
    show("c101_d1", 1, 7'b1000000);
    show("c101_d2", 2, 7'b1111001);
    show("c101_d3", 3, 7'h7F);

    score = 14'd42;
    n = 0;
    while (!busy && n < 10) begin @(negedge clock); n++; end
    cyc(3);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mrst_seg", seg, 7'b1000000);
    chk("mrst_an", an, 4'b1110);
    chk("mrst_busy", busy, 0);
    cyc(1);
    rst = 1'b0;
    wait_conv("c42");
    show("c42_d0", 0, 7'b0100100);
    show("c42_d1", 1, 7'b0011001);
    show("c42_d2", 2, 7'h7F);

`ifndef HISCORE_EN
    collide = 1'b1;
    n = 0;
    while (an !== 4'hF && n < 60) begin @(negedge clock); n++; end
    chk("blink_off", an, 4'hF);
    len = 0;
    while (an === 4'hF && len < 40) begin @(negedge clock); len++; end
    chk("blink_off_len", len, 8);
    len = 0;
    while (an !== 4'hF && len < 40) begin @(negedge clock); len++; end
    chk("blink_on_len", len, 8);
    collide = 1'b0;
    cyc(1);
    chk("unblink", (an !== 4'hF) && ($countones(~an) == 1), 1);
`else
    score = 14'd50;
    wait_conv("c50");
    collide = 1'b1;
    cyc(2);
    collide = 1'b0;
    score = 14'd30;
    wait_conv("c30");
    collide = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (an === 4'b1101 && seg === 7'b0010010) flag = 1'b1;
    end
    chk("hiscore_50", flag, 1);
    collide = 1'b0;
    cyc(2);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
